gray_conv_scheduler: RTL and testbench

- Shares one registered Gray-code conversion stage among N_REQ requesters.
- Each requester offers a WIDTH-bit word and a direction bit (binary-to-Gray or Gray-to-binary) over a valid/ready handshake.
- A round-robin arbiter admits at most one request per cycle into a single-entry output register, which the downstream consumer drains with its own valid/ready handshake.
- The block sits between multiple producer agents and a shared consumer of converted codes.

---
 rtl/gray_conv_scheduler.sv | 149 ++++++++++++++
 tb/tb_gray_conv_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_scheduler.sv
// rtl/gray_conv_scheduler.sv - round-robin shared binary/Gray conversion stage
//
// Purpose:
//   N_REQ producers compete for one registered Gray-code converter.
//   A round-robin arbiter admits at most one word per cycle into a single-entry
//   output register, which a shared consumer drains over a valid/ready handshake.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [N_REQ]        per-requester request valid
//   req_data   in   [N_REQ*WIDTH]  requester i at [i*WIDTH +: WIDTH]
//   req_dir    in   [N_REQ]        0 = binary-to-Gray, 1 = Gray-to-binary
//   req_ready  out  [N_REQ]        one-hot-or-zero accept strobe (combinational)
//   out_valid  out  converted word available
//   out_data   out  [WIDTH]        converted word
//   out_id     out  [ID_W]         requester that produced out_data
//   out_dir    out  direction used for out_data
//   out_ready  in   consumer accepts the output word
//   busy       out  out_valid || any req_valid

module gray_conv_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_dir,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [ID_W-1:0]        out_id,
  output logic                   out_dir,
  input  logic                   out_ready,
  output logic                   busy
);

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: running XOR from the MSB down.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // Registered state
  logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [ID_W-1:0]  out_id_q,    out_id_d;
  logic             out_dir_q,   out_dir_d;

  // Arbitration
  logic             slot_free;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic             xfer;
  int               cand;
  logic [WIDTH-1:0] sel_data;
  logic             sel_dir;
  logic [WIDTH-1:0] conv_data;

  // The slot can take a new word if it is empty or being drained this edge.
  assign slot_free = !out_valid_q || out_ready;

  // Search from rr_ptr+1 upward, wrapping, and keep the first valid hit.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // A grant only exists for a valid requester, so ready implies a transfer.
  assign xfer = grant_found && slot_free;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = xfer && (grant_idx == ID_W'(i));
    end
  end

  // Mux the granted word and direction into the shared converter.
  always_comb begin
    sel_data = req_data[int'(grant_idx)*WIDTH +: WIDTH];
    sel_dir  = req_dir[grant_idx];
    conv_data = sel_dir ? gray_to_bin(sel_data) : bin_to_gray(sel_data);
  end

  // Next-state: accept has priority; an accept on a draining edge replaces
  // the word, so one word per cycle streams through with out_ready high.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_dir_d   = out_dir_q;
    if (xfer) begin
      rr_ptr_d    = grant_idx;
      out_valid_d = 1'b1;
      out_data_d  = conv_data;
      out_id_d    = grant_idx;
      out_dir_d   = sel_dir;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_dir_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_dir_q   <= out_dir_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_dir   = out_dir_q;
  assign busy      = out_valid_q || (|req_valid);

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// tb/tb_gray_conv_scheduler.sv - self-checking bench for gray_conv_scheduler

module tb_gray_conv_scheduler;

  localparam int N_REQ = 4;
  localparam int WIDTH = 4;
  localparam int ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_dir;
  logic [N_REQ-1:0]       req_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [ID_W-1:0]        out_id;
  logic                   out_dir;
  logic                   out_ready;
  logic                   busy;

  gray_conv_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_dir   (req_dir),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_dir   (out_dir),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int               m_rr;
  bit               m_ov;
  logic [WIDTH-1:0] m_od;
  int               m_oid;
  bit               m_odir;

  logic [WIDTH-1:0] grays [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Gray-to-binary as the XOR of all right shifts of the code.
  function automatic logic [WIDTH-1:0] ref_conv(input logic [WIDTH-1:0] v, input bit d);
    logic [WIDTH-1:0] r;
    if (!d) return v ^ (v >> 1);
    r = '0;
    for (int s = 0; s < WIDTH; s++) r ^= v >> s;
    return r;
  endfunction

  task automatic model_reset();
    m_rr = N_REQ - 1; m_ov = 0; m_od = '0; m_oid = 0; m_odir = 0;
  endtask

  // One clock: check everything at the falling edge, then advance the model.
  task automatic cycle(output int acc);
    logic [N_REQ-1:0] exp_rdy;
    logic [WIDTH-1:0] d;
    bit dr;
    int g;
    @(negedge clk);
    g = -1;
    for (int k = 1; k <= N_REQ; k++) begin
      int i;
      i = (m_rr + k) % N_REQ;
      if (g < 0 && req_valid[i]) g = i;
    end
    exp_rdy = '0;
    if (g >= 0 && (!m_ov || out_ready)) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data",  32'(out_data),  32'(m_od));
    check("out_id",    32'(out_id),    32'(m_oid));
    check("out_dir",   32'(out_dir),   32'(m_odir));
    check("busy",      32'(busy),      32'(m_ov || (req_valid != 0)));
    if (g >= 0) begin
      d  = req_data[g*WIDTH +: WIDTH];
      dr = req_dir[g];
    end else begin
      d  = '0;
      dr = 0;
    end
    @(posedge clk); #1;
    acc = -1;
    if (exp_rdy != 0) begin
      acc = g; m_rr = g; m_ov = 1; m_od = ref_conv(d, dr); m_oid = g; m_odir = dr;
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] d, input bit dr);
    req_valid[i] = 1'b1;
    req_data[i*WIDTH +: WIDTH] = d;
    req_dir[i] = dr;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_dir = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    cycle(acc);

    // Single request, binary-to-Gray
    out_ready = 1'b1;
    set_req(2, 4'b1011, 1'b0);
    cycle(acc);
    check("single_acc", 32'(acc), 32'd2);
    req_valid = '0;
    #3;
    check("single_data", 32'(out_data), 32'b1110);
    check("single_id",   32'(out_id),   32'd2);
    check("single_vld",  32'(out_valid), 32'd1);
    cycle(acc);

    // All codes, back to back, then round trip
    for (int v = 0; v < 16; v++) begin
      set_req(0, 4'(v), 1'b0);
      cycle(acc);
      check("b2g_acc", 32'(acc), 32'd0);
      grays[v] = out_data;
    end
    check("b2g_1011", 32'(grays[11]), 32'b1110);
    for (int v = 0; v < 16; v++) begin
      set_req(0, grays[v], 1'b1);
      cycle(acc);
      check("g2b_acc", 32'(acc), 32'd0);
      check("g2b_round", 32'(out_data), 32'(v));
      check("g2b_dir", 32'(out_dir), 32'd1);
    end
    req_valid = '0;

    // Full contention: rr_ptr is 0, so service order starts at 1
    for (int i = 0; i < N_REQ; i++) set_req(i, 4'($urandom), 1'($urandom));
    for (int k = 0; k < 12; k++) begin
      cycle(acc);
      check("rr_order", 32'(acc), 32'((k + 1) % N_REQ));
      if (acc >= 0) set_req(acc, 4'($urandom), 1'($urandom));
    end

    // Backpressure with requesters 1 and 3 pending
    req_valid = '0;
    out_ready = 1'b0;
    set_req(1, 4'($urandom), 1'($urandom));
    set_req(3, 4'($urandom), 1'($urandom));
    for (int k = 0; k < 5; k++) begin
      cycle(acc);
      check("bp_hold", 32'(acc + 1), 32'd0);
    end
    out_ready = 1'b1;
    cycle(acc);
    check("bp_release", 32'(acc), 32'd1);
    req_valid[1] = 1'b0;
    cycle(acc);
    check("to_rr3", 32'(acc), 32'd3);

    // Withdrawal of requester 0 while blocked, rr_ptr wraps back to 3
    out_ready = 1'b0;
    set_req(0, 4'($urandom), 1'($urandom));
    set_req(3, 4'($urandom), 1'($urandom));
    for (int k = 0; k < 2; k++) begin
      cycle(acc);
      check("wd_block", 32'(acc + 1), 32'd0);
    end
    req_valid[0] = 1'b0;
    out_ready = 1'b1;
    cycle(acc);
    check("wd_grant3", 32'(acc), 32'd3);
    req_valid = '0;
    out_ready = 1'b0;
    cycle(acc);
    check("wd_out_id", 32'(out_id), 32'd3);

    // Asynchronous reset while a word is held
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_id",    32'(out_id),    32'd0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    set_req(0, 4'($urandom), 1'($urandom));
    set_req(2, 4'($urandom), 1'($urandom));
    cycle(acc);
    check("rst_first", 32'(acc), 32'd0);
    req_valid[0] = 1'b0;

    // Randomized traffic with withdrawals and backpressure
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          set_req(i, 4'($urandom), 1'($urandom));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc >= 0) req_valid[acc] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
